csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer, directly downstream of the hazard/trap-detect stage.
- Consumes the trap-commit pulse plus mcause/mtval from hazard control, and the mret signal; owns mstatus/mepc/mcause/mtval/mtvec/mscratch/mie and the 64-bit cycle/instret counters.
- Serves CSR instructions from the writeback stage and drives the PC redirect target for trap entry and mret.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14)
- MISA_VALUE, 32'h40000100, RV32I constant returned by misa (0x301)
- COUNTER_WIDTH, 64, width of mcycle/minstret

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low reset
- trapTaken  in  1  trap commit pulse from hazard control (its controlReset)
- trapCause  in  4  exception code (hazard mcause output)
- trapValue  in  32  faulting address (hazard mtval output)
- trapPc  in  32  PC of the faulting instruction (writeback stage)
- mretSignal  in  1  mret committing this cycle
- instretPulse  in  1  one instruction retired this cycle
- csrValid  in  1  CSR instruction in writeback
- csrOp  in  2  0=READ, 1=RW, 2=RS, 3=RC
- csrAddress  in  12  CSR address
- csrWriteData  in  32  rs1 value or zero-extended uimm
- csrReadData  out  32  old CSR value (combinational)
- csrIllegal  out  1  address unimplemented, or write to a read-only CSR
- redirectValid  out  1  fetch redirect this cycle
- redirectPc  out  32  redirect target
- interruptsEnabled  out  1  mstatus.MIE

Behaviour:
- Reset (reset==0 at a clock edge), all state cleared:
  - mstatus MIE=0, MPIE=0; MPP hardwired 2'b11
  - mtvec=0, so traps go to 0 until software sets mtvec
  - mepc, mcause, mtval, mscratch, mie, mcycle, minstret = 0
- Outputs are combinational from state and inputs. While reset==0, redirectValid=0 and csrIllegal=0.
- Priority each cycle: trapTaken > mretSignal > CSR write. A lower-priority event in the same cycle is discarded.
- Trap entry (trapTaken=1):
  - redirectValid=1 and redirectPc={mtvec[31:2],2'b00}, both in the same cycle. Only direct mode is supported; mtvec[1:0] is read-only 0.
  - Next edge: mepc<={trapPc[31:2],2'b00}; mcause<={28'b0,trapCause} (interrupt bit 0); mtval<=trapValue; MPIE<=MIE; MIE<=0.
- mret (without trap):
  - redirectValid=1 and redirectPc=current mepc, same cycle.
  - Next edge: MIE<=MPIE; MPIE<=1.
- CSR access (csrValid, no trap/mret):
  - csrReadData = pre-write value.
  - New value: RW=wd; RS=old|wd; RC=old&~wd; READ = no write.
  - Write lands at the clock edge and is visible to the next cycle's read.
  - csrIllegal=1 for an unknown address, or a write op to misa/mhartid/cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82). An illegal access changes no state and returns read data 0.
- Writable field masks:
  - mstatus: bits 3 and 7 only
  - mepc: bits[1:0] forced to 0
  - mie: bits 3, 7 and 11 only
  - mcause, mtval, mscratch: full 32 bits
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments on instretPulse, but not in a cycle with trapTaken.
  - Both wrap at 2^64-1 to 0.
  - Low and high halves are at 0xB00/0xB80 and 0xB02/0xB82. A CSR write to a half replaces that half and suppresses the increment for that counter in that cycle.
  - The carry from the low half into the high half is in the same cycle.
- Reset mid-trap: reset wins; no CSR update occurs.

Decomposition:
- Shared package:
  - csrOp_ enum
  - CSR address localparams
  - mstatus bit-position constants
  - exception code constants. Codes must match the hazard unit's mapping: 0–7, 0xB.
- Sub-module: csr_counter64, a 64-bit counter with increment, split low/high write and read. It is instantiated twice.

Test Plan:
- After reset, trapTaken=1, trapCause=2, trapValue=0x1234, trapPc=0x80 -> redirectPc=0 in the same cycle; next cycle mepc=0x80, mcause=2, mtval=0x1234, MIE=0.
- RW 0x305 wd=0x1003; then MIE set via RS 0x300 wd=0x8; then trap at pc 0x44 -> redirectPc=0x1000, MPIE=1, MIE=0. Then mret -> redirectPc=0x44, MIE=1, MPIE=1.
- Same cycle: trapTaken=1, mretSignal=1, csrValid RW 0x340 -> trap redirect only; mscratch unchanged; mstatus per trap.
- RS 0x340 wd=0xF0 on mscratch=0x0F -> read returns 0x0F; next read 0xFF. RC wd=0x0F -> 0xF0.
- RW 0xB00 wd=0xFFFFFFFF, then idle -> next cycle mcycleh increments by 1 and mcycle low reads 0. Write to 0xC00 -> csrIllegal=1 and no change. Read 0x7C0 -> csrIllegal=1, data 0.
- instretPulse=1 together with trapTaken=1 -> minstret unchanged. Reset asserted during an active trap cycle -> all CSRs 0 on the next cycle.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file: op encoding, CSR addresses,
// mstatus field positions, writable masks and exception codes.
package csr_trap_unit_pkg;

  typedef enum logic [1:0] {
    CSR_READ = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csrOp_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'h0;
  localparam logic [3:0] EXC_INSTR_FAULT      = 4'h1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'h2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'h3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'h4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'h5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'h6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'h7;
  localparam logic [3:0] EXC_ECALL_M          = 4'hB;

  function automatic logic [31:0] csrApply(input csrOp_e op, input logic [31:0] oldValue,
                                           input logic [31:0] writeData);
    case (op)
      CSR_RW:  csrApply = writeData;
      CSR_RS:  csrApply = oldValue | writeData;
      CSR_RC:  csrApply = oldValue & ~writeData;
      default: csrApply = oldValue;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// Free-running counter with split 32-bit half writes; a half write replaces
// that half and skips the increment for the cycle.
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        increment,
  input  logic        writeLow,
  input  logic        writeHigh,
  input  logic [31:0] writeData,
  output logic [31:0] readLow,
  output logic [31:0] readHigh
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (writeLow) begin
      count[31:0] <= writeData;
    end else if (writeHigh) begin
      count[WIDTH-1:32] <= (WIDTH-32)'(writeData);
    end else if (increment) begin
      count <= count + WIDTH'(1);
    end
  end

  assign readLow  = count[31:0];
  assign readHigh = 32'(count[WIDTH-1:32]);

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: trap entry and mret redirects,
// CSR read-modify-write, and the mcycle/minstret counters.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID       = 32'd0,
  parameter logic [31:0] MISA_VALUE    = 32'h4000_0100,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trapTaken,
  input  logic [3:0]  trapCause,
  input  logic [31:0] trapValue,
  input  logic [31:0] trapPc,
  input  logic        mretSignal,
  input  logic        instretPulse,
  input  logic        csrValid,
  input  logic [1:0]  csrOp,
  input  logic [11:0] csrAddress,
  input  logic [31:0] csrWriteData,
  output logic [31:0] csrReadData,
  output logic        csrIllegal,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        interruptsEnabled
);

  logic [31:0] mstatusReg;
  logic [31:0] mieReg;
  logic [31:0] mtvecReg;
  logic [31:0] mepcReg;
  logic [31:0] mcauseReg;
  logic [31:0] mtvalReg;
  logic [31:0] mscratchReg;

  logic [31:0] cycleLow, cycleHigh, instretLow, instretHigh;
  logic [31:0] oldValue, newValue;
  logic        known, readOnly, accessIllegal, csrWrite;
  csrOp_e      op;

  assign op = csrOp_e'(csrOp);

  always_comb begin
    oldValue = '0;
    known    = 1'b1;
    readOnly = 1'b0;
    case (csrAddress)
      CSR_MSTATUS:   oldValue = mstatusReg | MSTATUS_MPP_BITS;
      CSR_MISA:      begin oldValue = MISA_VALUE; readOnly = 1'b1; end
      CSR_MIE:       oldValue = mieReg;
      CSR_MTVEC:     oldValue = mtvecReg;
      CSR_MSCRATCH:  oldValue = mscratchReg;
      CSR_MEPC:      oldValue = mepcReg;
      CSR_MCAUSE:    oldValue = mcauseReg;
      CSR_MTVAL:     oldValue = mtvalReg;
      CSR_MCYCLE:    oldValue = cycleLow;
      CSR_MCYCLEH:   oldValue = cycleHigh;
      CSR_MINSTRET:  oldValue = instretLow;
      CSR_MINSTRETH: oldValue = instretHigh;
      CSR_CYCLE:     begin oldValue = cycleLow;    readOnly = 1'b1; end
      CSR_CYCLEH:    begin oldValue = cycleHigh;   readOnly = 1'b1; end
      CSR_INSTRET:   begin oldValue = instretLow;  readOnly = 1'b1; end
      CSR_INSTRETH:  begin oldValue = instretHigh; readOnly = 1'b1; end
      CSR_MHARTID:   begin oldValue = HART_ID;     readOnly = 1'b1; end
      default:       known = 1'b0;
    endcase
  end

  assign accessIllegal = csrValid && (!known || (readOnly && op != CSR_READ));
  assign newValue      = csrApply(op, oldValue, csrWriteData);
  // Trap and mret both outrank a CSR write issued in the same cycle.
  assign csrWrite      = csrValid && !accessIllegal && op != CSR_READ && !trapTaken && !mretSignal;

  assign csrReadData       = accessIllegal ? 32'd0 : oldValue;
  assign csrIllegal        = reset && accessIllegal;
  assign redirectValid     = reset && (trapTaken || mretSignal);
  assign redirectPc        = trapTaken ? (mtvecReg & ALIGN4_MASK) : mepcReg;
  assign interruptsEnabled = mstatusReg[MSTATUS_MIE];

  always_ff @(posedge clock) begin
    if (!reset) begin
      mstatusReg  <= '0;
      mieReg      <= '0;
      mtvecReg    <= '0;
      mepcReg     <= '0;
      mcauseReg   <= '0;
      mtvalReg    <= '0;
      mscratchReg <= '0;
    end else if (trapTaken) begin
      mepcReg                  <= trapPc & ALIGN4_MASK;
      mcauseReg                <= {28'b0, trapCause};
      mtvalReg                 <= trapValue;
      mstatusReg[MSTATUS_MPIE] <= mstatusReg[MSTATUS_MIE];
      mstatusReg[MSTATUS_MIE]  <= 1'b0;
    end else if (mretSignal) begin
      mstatusReg[MSTATUS_MIE]  <= mstatusReg[MSTATUS_MPIE];
      mstatusReg[MSTATUS_MPIE] <= 1'b1;
    end else if (csrWrite) begin
      case (csrAddress)
        CSR_MSTATUS:  mstatusReg  <= newValue & MSTATUS_WMASK;
        CSR_MIE:      mieReg      <= newValue & MIE_WMASK;
        CSR_MTVEC:    mtvecReg    <= newValue & ALIGN4_MASK;
        CSR_MSCRATCH: mscratchReg <= newValue;
        CSR_MEPC:     mepcReg     <= newValue & ALIGN4_MASK;
        CSR_MCAUSE:   mcauseReg   <= newValue;
        CSR_MTVAL:    mtvalReg    <= newValue;
        default: ;
      endcase
    end
  end

  csr_counter64 #(.WIDTH(COUNTER_WIDTH)) cycleCounter (
    .clock     (clock),
    .reset     (reset),
    .increment (1'b1),
    .writeLow  (csrWrite && csrAddress == CSR_MCYCLE),
    .writeHigh (csrWrite && csrAddress == CSR_MCYCLEH),
    .writeData (newValue),
    .readLow   (cycleLow),
    .readHigh  (cycleHigh)
  );

  // A retiring instruction that traps does not count as retired.
  csr_counter64 #(.WIDTH(COUNTER_WIDTH)) instretCounter (
    .clock     (clock),
    .reset     (reset),
    .increment (instretPulse && !trapTaken),
    .writeLow  (csrWrite && csrAddress == CSR_MINSTRET),
    .writeHigh (csrWrite && csrAddress == CSR_MINSTRETH),
    .writeData (newValue),
    .readLow   (instretLow),
    .readHigh  (instretHigh)
  );

endmodule
